// File: rtl/morse_pkg.sv
// Shared definitions for the Morse decoder input path: key codes, event kinds
// and the output-sequencer state encoding.
package morse_pkg;

    localparam logic [3:0] KEY_DASH   = 4'he;
    localparam logic [3:0] KEY_DOT    = 4'hf;
    localparam logic [3:0] KEY_COMMIT = 4'hd;
    localparam logic [3:0] KEY_BS     = 4'hc;

    localparam logic [2:0] MAX_SYM = 3'd5;

    typedef enum logic [1:0] {
        EV_DASH,
        EV_DOT,
        EV_COMMIT,
        EV_BS
    } ev_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP
    } state_e;

    function automatic logic [3:0] ev_code(input ev_e ev);
        case (ev)
            EV_DASH:   return KEY_DASH;
            EV_DOT:    return KEY_DOT;
            EV_COMMIT: return KEY_COMMIT;
            default:   return KEY_BS;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad press/release qualifier: one press pulse per debounced press, re-armed
// only by a debounced release.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] scan_key,
    input  logic       scan_valid,
    output logic       press,
    output logic [3:0] press_key
);

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [3:0]       key_q, key_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic [3:0]       code_q, code_d;

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        press_d = 1'b0;
        code_d  = code_q;

        // The key code only matters while something is held.
        if ((scan_valid != valid_q) || (scan_valid && (scan_key != key_q))) begin
            valid_d = scan_valid;
            key_d   = scan_key;
            cnt_d   = CNT_W'(1);
        end else if (cnt_q != DEB) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (cnt_d == DEB) begin
            if (scan_valid && armed_q) begin
                press_d = 1'b1;
                code_d  = scan_key;
                armed_d = 1'b0;
            end else if (!scan_valid) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            armed_q <= 1'b1;
            press_q <= 1'b0;
            code_q  <= '0;
        end else if (!en) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            armed_q <= 1'b1;
            press_q <= 1'b0;
            code_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            armed_q <= armed_d;
            press_q <= press_d;
            code_q  <= code_d;
        end
    end

    assign press     = press_q;
    assign press_key = code_q;

endmodule

// File: rtl/morse_input_ctrl.sv
// Input controller for the Morse decoder: classifies debounced presses, tracks
// pending symbols, buffers one event and strobes the decoder.
//   state    | meaning
//   S_IDLE   | no event in flight; serve pending slot first, else a new event
//   S_SETUP  | key driven, strobes low (one cycle of settling)
//   S_STROBE | flag or backspace high for PULSE_LEN cycles
//   S_GAP    | strobes low for PULSE_LEN cycles, key still held
module morse_input_ctrl
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int IDLE_CYC     = 100000000,
    parameter int PULSE_LEN    = 4,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] scan_key,
    input  logic       scan_valid,
    input  logic       auto_en,
    output logic [3:0] key,
    output logic       flag,
    output logic       backspace,
    output logic [2:0] sym_cnt,
    output logic       drop
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0]    PLAST     = PW'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

    logic       press;
    logic [3:0] press_key;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .scan_key  (scan_key),
        .scan_valid(scan_valid),
        .press     (press),
        .press_key (press_key)
    );

    state_e           state_q, state_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [3:0]       key_q, key_d;
    logic             bs_q, bs_d;
    logic             flag_q, flag_d;
    logic             bsp_q, bsp_d;
    logic             slot_vld_q, slot_vld_d;
    ev_e              slot_ev_q, slot_ev_d;
    logic [2:0]       sym_q, sym_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             drop_q, drop_d;

    logic kp_vld, auto_fire, new_vld, over, take, start;
    ev_e  kp_ev, new_ev, start_ev;

    always_comb begin
        kp_vld = 1'b0;
        kp_ev  = EV_DASH;
        if (press) begin
            case (press_key)
                KEY_DASH:   begin kp_vld = 1'b1; kp_ev = EV_DASH;   end
                KEY_DOT:    begin kp_vld = 1'b1; kp_ev = EV_DOT;    end
                KEY_COMMIT: begin kp_vld = 1'b1; kp_ev = EV_COMMIT; end
                KEY_BS:     begin kp_vld = 1'b1; kp_ev = EV_BS;     end
                default:    ;
            endcase
        end

        // A keypad event in the same cycle suppresses the auto-commit.
        auto_fire = auto_en && (sym_q != 3'd0) && (idle_q == IDLE_LAST) && !kp_vld;
        new_vld   = kp_vld || auto_fire;
        new_ev    = kp_vld ? kp_ev : EV_COMMIT;
        over      = ((new_ev == EV_DASH) || (new_ev == EV_DOT)) && (sym_q == MAX_SYM);
        take      = new_vld && !over && ((state_q == S_IDLE) || !slot_vld_q);
        drop_d    = new_vld && !take;

        sym_d = sym_q;
        if (take) begin
            case (new_ev)
                EV_DASH, EV_DOT: sym_d = sym_q + 3'd1;
                EV_BS:           sym_d = (sym_q == 3'd0) ? 3'd0 : sym_q - 3'd1;
                default:         sym_d = 3'd0;
            endcase
        end

        if (new_vld)
            idle_d = '0;
        else if (idle_q != IDLE_LAST)
            idle_d = idle_q + CNT_W'(1);
        else
            idle_d = idle_q;

        state_d    = state_q;
        pcnt_d     = pcnt_q;
        key_d      = key_q;
        bs_d       = bs_q;
        slot_vld_d = slot_vld_q;
        slot_ev_d  = slot_ev_q;
        start      = 1'b0;
        start_ev   = new_ev;

        case (state_q)
            S_IDLE: begin
                if (slot_vld_q) begin
                    start      = 1'b1;
                    start_ev   = slot_ev_q;
                    slot_vld_d = take;
                    if (take) slot_ev_d = new_ev;
                end else if (take) begin
                    start = 1'b1;
                end
                if (start) begin
                    state_d = S_SETUP;
                    key_d   = ev_code(start_ev);
                    bs_d    = (start_ev == EV_BS);
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                pcnt_d  = '0;
            end
            S_STROBE, S_GAP: begin
                if (pcnt_q == PLAST) begin
                    state_d = (state_q == S_STROBE) ? S_GAP : S_IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && take) begin
            slot_vld_d = 1'b1;
            slot_ev_d  = new_ev;
        end

        flag_d = (state_d == S_STROBE) && !bs_d;
        bsp_d  = (state_d == S_STROBE) && bs_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            key_q      <= '0;
            bs_q       <= 1'b0;
            flag_q     <= 1'b0;
            bsp_q      <= 1'b0;
            slot_vld_q <= 1'b0;
            slot_ev_q  <= EV_DASH;
            sym_q      <= '0;
            idle_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            key_q      <= key_d;
            bs_q       <= bs_d;
            flag_q     <= flag_d;
            bsp_q      <= bsp_d;
            slot_vld_q <= slot_vld_d;
            slot_ev_q  <= slot_ev_d;
            sym_q      <= sym_d;
            idle_q     <= idle_d;
            drop_q     <= drop_d;
        end
    end

    assign key       = key_q;
    assign flag      = flag_q;
    assign backspace = bsp_q;
    assign sym_cnt   = sym_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_morse_input_ctrl.sv
// Bench for morse_input_ctrl: directed scenarios plus randomized press
// sequences checked against an event-level model of the keypad rules.
module tb_morse_input_ctrl;

    typedef struct {
        logic [3:0] key;
        int         width;
        bit         bs;
        bit         key_ok;
        int         rise;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] scan_key = 4'h0, scan_key_s = 4'h0;
    logic       scan_valid = 1'b0, scan_valid_s = 1'b0;
    logic       auto_en = 1'b0, auto_en_s = 1'b0;
    logic [3:0] key, key_s;
    logic       flag, flag_s, backspace, backspace_s, drop, drop_s;
    logic [2:0] sym_cnt, sym_cnt_s;

    int checks = 0;
    int errors = 0;

    morse_input_ctrl #(.DEBOUNCE_CYC(4), .IDLE_CYC(50), .PULSE_LEN(2), .CNT_W(27)) u_dut (
        .clk(clk), .rst(rst), .en(en), .scan_key(scan_key), .scan_valid(scan_valid),
        .auto_en(auto_en), .key(key), .flag(flag), .backspace(backspace),
        .sym_cnt(sym_cnt), .drop(drop)
    );

    // Long strobes make the pending slot reachable with 4-cycle debounce.
    morse_input_ctrl #(.DEBOUNCE_CYC(4), .IDLE_CYC(50), .PULSE_LEN(8), .CNT_W(27)) u_dut_slow (
        .clk(clk), .rst(rst), .en(en), .scan_key(scan_key_s), .scan_valid(scan_valid_s),
        .auto_en(auto_en_s), .key(key_s), .flag(flag_s), .backspace(backspace_s),
        .sym_cnt(sym_cnt_s), .drop(drop_s)
    );

    always #5 clk = ~clk;

    pulse_t     pq_f[$], pq_s[$];
    pulse_t     cur[2];
    bit         st_prev[2];
    logic [3:0] key_prev[2];
    bit         drop_prev[2];
    int         drops_f = 0, drops_s = 0, dlong = 0;
    int         cyc_n = 0;
    logic       m_on, m_bs, m_drop;
    logic [3:0] m_key;

    always @(negedge clk) begin
        cyc_n++;
        for (int u = 0; u < 2; u++) begin
            m_on   = (u != 0) ? (flag_s | backspace_s) : (flag | backspace);
            m_bs   = (u != 0) ? backspace_s : backspace;
            m_key  = (u != 0) ? key_s : key;
            m_drop = (u != 0) ? drop_s : drop;
            if (rst) begin
                st_prev[u]   = 1'b0;
                key_prev[u]  = 4'h0;
                drop_prev[u] = 1'b0;
            end else begin
                if (m_on && !st_prev[u]) begin
                    cur[u].key    = m_key;
                    cur[u].width  = 1;
                    cur[u].bs     = m_bs;
                    cur[u].key_ok = (m_key === key_prev[u]);
                    cur[u].rise   = cyc_n;
                end else if (m_on) begin
                    cur[u].width++;
                    if (m_key !== cur[u].key) cur[u].key_ok = 1'b0;
                end else if (st_prev[u]) begin
                    if (u == 0) pq_f.push_back(cur[u]);
                    else        pq_s.push_back(cur[u]);
                end
                if (m_drop === 1'b1) begin
                    if (u == 0) drops_f++;
                    else        drops_s++;
                    if (drop_prev[u]) dlong++;
                end
                st_prev[u]   = m_on;
                key_prev[u]  = m_key;
                drop_prev[u] = m_drop;
            end
        end
    end

    task automatic apply_reset();
        rst          = 1'b1;
        scan_valid   = 1'b0;
        scan_valid_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pq_f.delete();
        pq_s.delete();
        drops_f = 0;
        drops_s = 0;
        dlong   = 0;
    endtask

    task automatic seg(input bit v, input logic [3:0] k, input int n);
        scan_valid = v;
        scan_key   = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic seg_s(input bit v, input logic [3:0] k, input int n);
        scan_valid_s = v;
        scan_key_s   = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (key !== 4'h0)     begin errors++; $display("FAIL reset_key: got %0h expected 0", key); end
        checks++; if (flag !== 1'b0)    begin errors++; $display("FAIL reset_flag: got %0b expected 0", flag); end
        checks++; if (backspace !== 1'b0) begin errors++; $display("FAIL reset_bs: got %0b expected 0", backspace); end
        checks++; if (sym_cnt !== 3'd0) begin errors++; $display("FAIL reset_sym: got %0d expected 0", sym_cnt); end
        checks++; if (drop !== 1'b0)    begin errors++; $display("FAIL reset_drop: got %0b expected 0", drop); end
    endtask

    task automatic check_single_dot(input string tag);
        checks++;
        if (pq_f.size() != 1) begin
            errors++; $display("FAIL %s_count: got %0d pulses expected 1", tag, pq_f.size());
        end else begin
            checks++; if (pq_f[0].key !== 4'hf) begin errors++; $display("FAIL %s_key: got %0h expected f", tag, pq_f[0].key); end
            checks++; if (pq_f[0].width != 2)   begin errors++; $display("FAIL %s_width: got %0d expected 2", tag, pq_f[0].width); end
            checks++; if (pq_f[0].bs)           begin errors++; $display("FAIL %s_strobe: got backspace expected flag", tag); end
            checks++; if (!pq_f[0].key_ok)      begin errors++; $display("FAIL %s_key_settle: got 0 expected 1", tag); end
        end
        checks++; if (sym_cnt !== 3'd1) begin errors++; $display("FAIL %s_sym: got %0d expected 1", tag, sym_cnt); end
    endtask

    task automatic test_single_dot();
        apply_reset();
        seg(1, 4'hf, 10);
        seg(0, 4'h0, 10);
        check_single_dot("dot");
    endtask

    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            seg(1, 4'he, 2);
            seg(1, 4'hf, 2);
        end
        seg(0, 4'h0, 10);
        checks++; if (pq_f.size() != 0) begin errors++; $display("FAIL bounce_count: got %0d pulses expected 0", pq_f.size()); end
        checks++; if (sym_cnt !== 3'd0)  begin errors++; $display("FAIL bounce_sym: got %0d expected 0", sym_cnt); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            seg(1, 4'he, 6);
            seg(0, 4'h0, 6);
        end
        seg(0, 4'h0, 6);
        checks++;
        if (pq_f.size() != 5) begin
            errors++; $display("FAIL ovf_count: got %0d pulses expected 5", pq_f.size());
        end
        for (int i = 0; i < pq_f.size(); i++) begin
            checks++;
            if (pq_f[i].key !== 4'he || pq_f[i].width != 2 || pq_f[i].bs) begin
                errors++; $display("FAIL ovf_pulse%0d: got key %0h width %0d bs %0b expected e/2/0",
                                   i, pq_f[i].key, pq_f[i].width, pq_f[i].bs);
            end
        end
        checks++; if (drops_f != 1)     begin errors++; $display("FAIL ovf_drops: got %0d expected 1", drops_f); end
        checks++; if (dlong != 0)       begin errors++; $display("FAIL ovf_drop_len: got %0d long pulses expected 0", dlong); end
        checks++; if (sym_cnt !== 3'd5) begin errors++; $display("FAIL ovf_sym: got %0d expected 5", sym_cnt); end
    endtask

    task automatic test_auto_commit();
        apply_reset();
        auto_en = 1'b1;
        seg(1, 4'hf, 5);
        seg(0, 4'h0, 80);
        checks++;
        if (pq_f.size() != 2) begin
            errors++; $display("FAIL auto_count: got %0d pulses expected 2", pq_f.size());
        end else begin
            checks++; if (pq_f[1].key !== 4'hd || pq_f[1].bs) begin errors++; $display("FAIL auto_key: got %0h expected d", pq_f[1].key); end
            checks++; if (pq_f[1].rise - pq_f[0].rise != 50) begin
                errors++; $display("FAIL auto_delay: got %0d expected 50", pq_f[1].rise - pq_f[0].rise);
            end
        end
        checks++; if (sym_cnt !== 3'd0) begin errors++; $display("FAIL auto_sym: got %0d expected 0", sym_cnt); end

        apply_reset();
        auto_en = 1'b0;
        seg(1, 4'hf, 5);
        seg(0, 4'h0, 80);
        checks++; if (pq_f.size() != 1) begin errors++; $display("FAIL noauto_count: got %0d pulses expected 1", pq_f.size()); end
        checks++; if (sym_cnt !== 3'd1) begin errors++; $display("FAIL noauto_sym: got %0d expected 1", sym_cnt); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        seg_s(1, 4'he, 4);
        seg_s(0, 4'h0, 4);
        seg_s(1, 4'hc, 4);
        seg_s(0, 4'h0, 4);
        seg_s(1, 4'hf, 4);
        seg_s(0, 4'h0, 40);
        checks++;
        if (pq_s.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d pulses expected 2", pq_s.size());
        end else begin
            checks++; if (pq_s[0].key !== 4'he || pq_s[0].bs || pq_s[0].width != 8) begin
                errors++; $display("FAIL b2b_dash: got key %0h bs %0b width %0d expected e/0/8", pq_s[0].key, pq_s[0].bs, pq_s[0].width);
            end
            checks++; if (pq_s[1].key !== 4'hc || !pq_s[1].bs || pq_s[1].width != 8 || !pq_s[1].key_ok) begin
                errors++; $display("FAIL b2b_bs: got key %0h bs %0b width %0d expected c/1/8", pq_s[1].key, pq_s[1].bs, pq_s[1].width);
            end
            checks++; if (pq_s[1].rise - pq_s[0].rise != 18) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 18", pq_s[1].rise - pq_s[0].rise);
            end
        end
        checks++; if (drops_s != 1)       begin errors++; $display("FAIL b2b_drops: got %0d expected 1", drops_s); end
        checks++; if (sym_cnt_s !== 3'd0) begin errors++; $display("FAIL b2b_sym: got %0d expected 0", sym_cnt_s); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        apply_reset();
        scan_valid = 1'b1;
        scan_key   = 4'hf;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (flag === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rstmid_wait: got no flag within 20 cycles expected flag");
        end else begin
            #2 rst = 1'b1;
            #1;
            checks++; if (flag !== 1'b0)    begin errors++; $display("FAIL rstmid_flag: got %0b expected 0", flag); end
            checks++; if (key !== 4'h0)     begin errors++; $display("FAIL rstmid_key: got %0h expected 0", key); end
            checks++; if (sym_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_sym: got %0d expected 0", sym_cnt); end
        end
        apply_reset();
        seg(1, 4'hf, 10);
        seg(0, 4'h0, 10);
        check_single_dot("rstmid_dot");
    endtask

    task automatic test_random();
        pulse_t     exp_q[$];
        pulse_t     p;
        int         exp_sym = 0, exp_drops = 0;
        bit         armed = 1'b1, pv = 1'b0;
        logic [3:0] pk = 4'h0;
        apply_reset();
        auto_en = 1'b0;
        for (int i = 0; i < 80; i++) begin
            bit         v   = 1'($urandom_range(0, 1));
            int         len = $urandom_range(1, 7);
            int         r   = $urandom_range(0, 7);
            logic [3:0] k;
            if (!pv && !v) v = 1'b1;
            case (r)
                0: k = 4'hc;
                1: k = 4'hd;
                2, 3: k = 4'he;
                4, 5: k = 4'hf;
                default: k = 4'($urandom_range(0, 11));
            endcase
            if (v && pv && k == pk) k = k ^ 4'h1;
            seg(v, k, len);
            if (v && len >= 4 && armed) begin
                armed = 1'b0;
                p.width = 2; p.key_ok = 1'b1; p.rise = 0; p.key = k; p.bs = 1'b0;
                if (k == 4'he || k == 4'hf) begin
                    if (exp_sym < 5) begin exp_sym++; exp_q.push_back(p); end
                    else exp_drops++;
                end else if (k == 4'hc) begin
                    if (exp_sym > 0) exp_sym--;
                    p.bs = 1'b1;
                    exp_q.push_back(p);
                end else if (k == 4'hd) begin
                    exp_sym = 0;
                    exp_q.push_back(p);
                end
            end else if (!v && len >= 4) begin
                armed = 1'b1;
            end
            pv = v;
            pk = k;
        end
        seg(0, 4'h0, 20);
        checks++;
        if (pq_f.size() != exp_q.size()) begin
            errors++; $display("FAIL rnd_count: got %0d pulses expected %0d", pq_f.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < pq_f.size(); i++) begin
            checks++;
            if (pq_f[i].key !== exp_q[i].key || pq_f[i].bs != exp_q[i].bs ||
                pq_f[i].width != 2 || !pq_f[i].key_ok) begin
                errors++; $display("FAIL rnd_pulse%0d: got key %0h bs %0b width %0d expected key %0h bs %0b width 2",
                                   i, pq_f[i].key, pq_f[i].bs, pq_f[i].width, exp_q[i].key, exp_q[i].bs);
            end
        end
        checks++; if (drops_f != exp_drops)      begin errors++; $display("FAIL rnd_drops: got %0d expected %0d", drops_f, exp_drops); end
        checks++; if (sym_cnt !== 3'(exp_sym))   begin errors++; $display("FAIL rnd_sym: got %0d expected %0d", sym_cnt, exp_sym); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_dot();
        test_bounce();
        test_overflow();
        test_auto_commit();
        test_back_to_back();
        test_reset_mid();
        for (int n = 0; n < 4; n++) test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
